// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the issue queue entry layout.
package cpu_pkg;

    localparam int CPU_TAG_W  = 4;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_OP_W   = 6;
    localparam int CPU_IMM_W  = 32;
    localparam int CPU_PC_W   = 32;

    typedef struct packed {
        logic                  pending;
        logic [CPU_TAG_W-1:0]  tag;
        logic [CPU_DATA_W-1:0] val;
    } iq_src_t;

    typedef struct packed {
        logic                 busy;
        logic [CPU_OP_W-1:0]  op;
        logic [CPU_PC_W-1:0]  pc;
        logic [CPU_IMM_W-1:0] imm;
        logic [CPU_TAG_W-1:0] rd_tag;
        iq_src_t              src1;
        iq_src_t              src2;
    } iq_entry_t;

    function automatic logic iq_entry_ready(input iq_entry_t e);
        return e.busy && !e.src1.pending && !e.src2.pending;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Issue selection: one-hot grant over the ready vector.
// ISSUE_QUEUE_AGE_ORDER_EN selects oldest-first via an age matrix; otherwise lowest index wins.
module iq_select
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [DEPTH-1:0] alloc_oh,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant,
    output logic             valid
);

    assign valid = |ready;

`ifdef ISSUE_QUEUE_AGE_ORDER_EN
    // age[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0] age [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else if (alloc_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    age[i] <= '0;
                end else begin
                    age[i] <= age[i] | alloc_oh;
                end
            end
        end
    end

    always_comb begin
        logic oldest;
        grant  = '0;
        oldest = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && !age[i][j]) begin
                    oldest = 1'b0;
                end
            end
            grant[i] = oldest;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = ^{clk, rst, alloc_en, alloc_oh};

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue with CDB wakeup, dispatch bypass and a registered issue slot.
// Define ISSUE_QUEUE_AGE_ORDER_EN for oldest-first selection instead of lowest-index.
module issue_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NCDB   = 3,
    parameter int TAG_W  = CPU_TAG_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter int OP_W   = CPU_OP_W,
    parameter int IMM_W  = CPU_IMM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [31:0]                in_pc,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [TAG_W-1:0]           in_rd_tag,
    input  logic                       in_src1_busy,
    input  logic                       in_src2_busy,
    input  logic [TAG_W-1:0]           in_src1_tag,
    input  logic [TAG_W-1:0]           in_src2_tag,
    input  logic [DATA_W-1:0]          in_src1_val,
    input  logic [DATA_W-1:0]          in_src2_val,
    input  logic [NCDB-1:0]            cdb_valid,
    input  logic [NCDB*TAG_W-1:0]      cdb_tag,
    input  logic [NCDB*DATA_W-1:0]     cdb_val,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [31:0]                iss_pc,
    output logic [IMM_W-1:0]           iss_imm,
    output logic [TAG_W-1:0]           iss_rd_tag,
    output logic [DATA_W-1:0]          iss_src1_val,
    output logic [DATA_W-1:0]          iss_src2_val,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t        ent   [DEPTH];
    iq_entry_t        ent_n [DEPTH];
    iq_entry_t        new_ent;
    iq_entry_t        sel_ent;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] grant;
    logic             sel_valid;
    logic             dispatch;
    logic             load;
    logic [CNT_W-1:0] count_n;

    // {hit, value}; scanning downwards lets the lowest-numbered port win
    function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                r = {1'b1, cdb_val[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    assign in_ready = (count != CNT_W'(DEPTH));
    assign dispatch = in_valid && in_ready && !flush;

    // Issue handshake: a transfer occurs on an edge where iss_valid && iss_ready;
    // the slot reloads only when empty or transferring, so iss_* hold while stalled.
    assign load = sel_valid && (!iss_valid || iss_ready);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = iq_entry_ready(ent[i]);
        end
    end

    always_comb begin
        logic found;
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent[i].busy && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    iq_select #(
        .DEPTH(DEPTH)
    ) u_select (
        .clk      (clk),
        .rst      (rst),
        .alloc_en (rdy && dispatch),
        .alloc_oh (free_oh),
        .ready    (ready_vec),
        .grant    (grant),
        .valid    (sel_valid)
    );

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent[i];
            end
        end
    end

    always_comb begin
        logic [DATA_W:0] look1;
        logic [DATA_W:0] look2;
        look1            = cdb_match(in_src1_tag);
        look2            = cdb_match(in_src2_tag);
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.op       = in_op;
        new_ent.pc       = in_pc;
        new_ent.imm      = in_imm;
        new_ent.rd_tag   = in_rd_tag;
        new_ent.src1.tag = in_src1_tag;
        new_ent.src2.tag = in_src2_tag;
        new_ent.src1.pending = in_src1_busy && !look1[DATA_W];
        new_ent.src2.pending = in_src2_busy && !look2[DATA_W];
        new_ent.src1.val = (in_src1_busy && look1[DATA_W]) ? look1[DATA_W-1:0] : in_src1_val;
        new_ent.src2.val = (in_src2_busy && look2[DATA_W]) ? look2[DATA_W-1:0] : in_src2_val;
    end

    always_comb begin
        logic [DATA_W:0] wk;
        wk = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = ent[i];
            if (ent[i].busy && ent[i].src1.pending) begin
                wk = cdb_match(ent[i].src1.tag);
                if (wk[DATA_W]) begin
                    ent_n[i].src1.pending = 1'b0;
                    ent_n[i].src1.val     = wk[DATA_W-1:0];
                end
            end
            if (ent[i].busy && ent[i].src2.pending) begin
                wk = cdb_match(ent[i].src2.tag);
                if (wk[DATA_W]) begin
                    ent_n[i].src2.pending = 1'b0;
                    ent_n[i].src2.val     = wk[DATA_W-1:0];
                end
            end
            if (load && grant[i]) begin
                ent_n[i].busy = 1'b0;
            end
            if (dispatch && free_oh[i]) begin
                ent_n[i] = new_ent;
            end
        end
    end

    always_comb begin
        count_n = count;
        if (dispatch && !load) begin
            count_n = count + 1'b1;
        end else if (!dispatch && load) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            iss_valid    <= 1'b0;
            iss_op       <= '0;
            iss_pc       <= '0;
            iss_imm      <= '0;
            iss_rd_tag   <= '0;
            iss_src1_val <= '0;
            iss_src2_val <= '0;
            count        <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i].busy <= 1'b0;
                end
                iss_valid <= 1'b0;
                count     <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i] <= ent_n[i];
                end
                count <= count_n;
                if (load) begin
                    iss_valid    <= 1'b1;
                    iss_op       <= sel_ent.op;
                    iss_pc       <= sel_ent.pc;
                    iss_imm      <= sel_ent.imm;
                    iss_rd_tag   <= sel_ent.rd_tag;
                    iss_src1_val <= sel_ent.src1.val;
                    iss_src2_val <= sel_ent.src2.val;
                end else if (iss_ready) begin
                    iss_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-level behavioural model.
module tb_issue_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_pc, in_imm;
    logic [3:0]  in_rd_tag, in_src1_tag, in_src2_tag;
    logic        in_src1_busy, in_src2_busy;
    logic [31:0] in_src1_val, in_src2_val;
    logic [2:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [95:0] cdb_val;
    logic        iss_valid, iss_ready;
    logic [5:0]  iss_op;
    logic [31:0] iss_pc, iss_imm, iss_src1_val, iss_src2_val;
    logic [3:0]  iss_rd_tag;
    logic [4:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    issue_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_rd_tag(in_rd_tag),
        .in_src1_busy(in_src1_busy), .in_src2_busy(in_src2_busy),
        .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
        .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_rd_tag(iss_rd_tag),
        .iss_src1_val(iss_src1_val), .iss_src2_val(iss_src2_val),
        .count(count)
    );

    // Model: an unordered pool of waiting instructions plus one output slot.
    typedef struct {
        bit          busy;
        logic [5:0]  op;
        logic [31:0] pc, imm;
        logic [3:0]  rd;
        bit          p1, p2;
        logic [3:0]  t1, t2;
        logic [31:0] v1, v2;
        int unsigned seq;
    } m_ent_t;

    m_ent_t      m [16];
    bit          m_iv;
    logic [5:0]  m_op;
    logic [31:0] m_pc, m_imm, m_v1, m_v2;
    logic [3:0]  m_rd;
    int unsigned seq_ctr = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic bit cdb_find(input logic [3:0] tag, output logic [31:0] v);
        v = '0;
        for (int k = 0; k < 3; k++) begin
            if (cdb_valid[k] && cdb_tag[k*4 +: 4] == tag) begin
                v = cdb_val[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int          sel;
        int          free;
        bit          do_disp, do_load;
        logic [31:0] v;
        sel  = -1;
        free = -1;
        if (rst) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            m_iv = 0; m_op = '0; m_pc = '0; m_imm = '0; m_rd = '0; m_v1 = '0; m_v2 = '0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            m_iv = 0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && !m[i].p1 && !m[i].p2) begin
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
                if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
            if (!m[i].busy && free < 0) free = i;
        end
        do_disp = in_valid && (m_count() != 16);
        do_load = (sel >= 0) && (!m_iv || iss_ready);
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && m[i].p1 && cdb_find(m[i].t1, v)) begin m[i].p1 = 0; m[i].v1 = v; end
            if (m[i].busy && m[i].p2 && cdb_find(m[i].t2, v)) begin m[i].p2 = 0; m[i].v2 = v; end
        end
        if (do_load) begin
            m_iv = 1; m_op = m[sel].op; m_pc = m[sel].pc; m_imm = m[sel].imm;
            m_rd = m[sel].rd; m_v1 = m[sel].v1; m_v2 = m[sel].v2;
            m[sel].busy = 0;
        end else if (iss_ready) begin
            m_iv = 0;
        end
        if (do_disp) begin
            m[free].busy = 1; m[free].op = in_op; m[free].pc = in_pc; m[free].imm = in_imm;
            m[free].rd = in_rd_tag; m[free].t1 = in_src1_tag; m[free].t2 = in_src2_tag;
            m[free].p1 = in_src1_busy; m[free].v1 = in_src1_val;
            m[free].p2 = in_src2_busy; m[free].v2 = in_src2_val;
            if (in_src1_busy && cdb_find(in_src1_tag, v)) begin m[free].p1 = 0; m[free].v1 = v; end
            if (in_src2_busy && cdb_find(in_src2_tag, v)) begin m[free].p2 = 0; m[free].v2 = v; end
            m[free].seq = seq_ctr;
            seq_ctr++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_outputs();
        chk("count", 64'(count), 64'(m_count()));
        chk("in_ready", 64'(in_ready), 64'(m_count() != 16));
        chk("iss_valid", 64'(iss_valid), 64'(m_iv));
        if (m_iv) begin
            chk("iss_pc", 64'(iss_pc), 64'(m_pc));
            chk("iss_op", 64'(iss_op), 64'(m_op));
            chk("iss_imm", 64'(iss_imm), 64'(m_imm));
            chk("iss_rd_tag", 64'(iss_rd_tag), 64'(m_rd));
            chk("iss_src1_val", 64'(iss_src1_val), 64'(m_v1));
            chk("iss_src2_val", 64'(iss_src2_val), 64'(m_v2));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; in_valid = 0; cdb_valid = '0;
    endtask

    task automatic set_disp(input logic [31:0] pc, input bit b1, input logic [3:0] t1,
                            input logic [31:0] v1, input bit b2, input logic [3:0] t2,
                            input logic [31:0] v2);
        in_valid = 1; in_pc = pc; in_op = 6'($urandom); in_imm = $urandom;
        in_rd_tag = 4'($urandom);
        in_src1_busy = b1; in_src1_tag = t1; in_src1_val = v1;
        in_src2_busy = b2; in_src2_tag = t2; in_src2_val = v2;
    endtask

    task automatic set_cdb(input int port, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[port] = 1'b1;
        cdb_tag[port*4 +: 4] = tag;
        cdb_val[port*32 +: 32] = val;
    endtask

    initial begin
        logic [31:0] first_pc, second_pc;
        idle();
        iss_ready = 1; cdb_tag = '0; cdb_val = '0;
        set_disp(32'h0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
        in_valid = 0;
        for (int i = 0; i < 16; i++) m[i] = '{default: 0};
        @(negedge clk);
        rst = 1;
        step();
        step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_iss_pc", 64'(iss_pc), 64'd0);

        // Both sources ready: issues one cycle after dispatch.
        idle(); iss_ready = 1;
        set_disp(32'h100, 0, 4'h0, 32'h11, 0, 4'h0, 32'h22);
        step();
        chk("simple_count_after_disp", 64'(count), 64'd1);
        idle(); step();
        chk("simple_iss_valid", 64'(iss_valid), 64'd1);
        chk("simple_iss_pc", 64'(iss_pc), 64'h100);
        chk("simple_count_back", 64'(count), 64'd0);
        idle(); step();

        // Late wakeup from CDB port 2.
        set_disp(32'h200, 1, 4'd5, 32'h0, 0, 4'h0, 32'h7);
        step();
        idle(); step();
        set_cdb(2, 4'd5, 32'hDEADBEEF);
        step();
        chk("wake_not_yet_issued", 64'(iss_valid), 64'd0);
        idle(); step();
        chk("wake_iss_valid", 64'(iss_valid), 64'd1);
        chk("wake_src1", 64'(iss_src1_val), 64'hDEADBEEF);
        idle(); step();

        // Dispatch bypass on both sources with the same tag.
        set_disp(32'h300, 1, 4'd3, 32'h0, 1, 4'd3, 32'h0);
        set_cdb(0, 4'd3, 32'h12345678);
        step();
        idle(); step();
        chk("bypass_iss_valid", 64'(iss_valid), 64'd1);
        chk("bypass_src1", 64'(iss_src1_val), 64'h12345678);
        chk("bypass_src2", 64'(iss_src2_val), 64'h12345678);
        idle(); step();

        // Fill with the functional unit stalled.
        idle(); iss_ready = 0;
        for (int i = 0; i < 40 && in_ready; i++) begin
            set_disp(32'h1000 + 32'(i), 0, 4'h0, 32'(i), 0, 4'h0, 32'(i));
            step();
        end
        idle();
        chk("full_count", 64'(count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_iss_pc", 64'(iss_pc), 64'h1000);
        set_disp(32'h2000, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
        step();
        chk("drop_count", 64'(count), 64'd16);
        chk("stall_iss_pc", 64'(iss_pc), 64'h1000);
        idle(); iss_ready = 1;
        for (int i = 0; i < 20; i++) step();
        chk("drain_count", 64'(count), 64'd0);

        // Ordering: A sits in entry 3, B lands in entry 0 later; both wake together.
        idle(); set_disp(32'h50, 1, 4'd9, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); set_disp(32'h51, 1, 4'd10, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); set_disp(32'h52, 1, 4'd10, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); set_disp(32'hA0, 1, 4'd12, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); set_cdb(0, 4'd9, 32'h1); step();
        idle(); step();
        chk("age_e0_pc", 64'(iss_pc), 64'h50);
        idle(); set_disp(32'hB0, 1, 4'd12, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); set_cdb(1, 4'd12, 32'h77); step();
        idle(); step();
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
        first_pc = 32'hA0; second_pc = 32'hB0;
`else
        first_pc = 32'hB0; second_pc = 32'hA0;
`endif
        chk("order_first", 64'(iss_pc), 64'(first_pc));
        step();
        chk("order_second", 64'(iss_pc), 64'(second_pc));
        idle(); set_cdb(0, 4'd10, 32'h5); step();
        idle();
        for (int i = 0; i < 5; i++) step();
        chk("order_drained", 64'(count), 64'd0);

        // Flush with 7 waiting and the slot occupied.
        idle(); iss_ready = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_count() == 7 && m_iv) break;
            set_disp(32'h3000 + 32'(i), 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
            step();
        end
        idle();
        chk("preflush_count", 64'(count), 64'd7);
        chk("preflush_iss_valid", 64'(iss_valid), 64'd1);
        set_disp(32'h4000, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);
        flush = 1;
        step();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);

        // rdy low freezes everything.
        idle(); set_disp(32'h500, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0); step();
        idle(); rdy = 0; in_valid = 1; step();
        chk("freeze_count", 64'(count), 64'd1);
        chk("freeze_iss_valid", 64'(iss_valid), 64'd0);
        idle(); step();
        chk("unfreeze_iss_pc", 64'(iss_pc), 64'h500);

        // Reset discards a stalled slot.
        idle(); rst = 1; step();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_pc", 64'(iss_pc), 64'd0);
        chk("rst_count", 64'(count), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            flush = rdy && ($urandom_range(0, 49) == 0);
            iss_ready = ($urandom_range(0, 9) < 7);
            set_disp($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                     1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            in_valid = 1'($urandom_range(0, 1));
            cdb_valid = 3'($urandom);
            cdb_tag = 12'($urandom);
            cdb_val = {$urandom, $urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
